// File: rtl/tube_column_gen_if.sv
// Pixel-query and scroll-control bundle for tube_column_gen.
// master drives tick/run/gap/pixel coordinates; slave returns colour, mask and event pulses.
interface tube_column_gen_if;
  logic        frame_tick;
  logic        run;
  logic [10:0] gap_y_in;
  logic [10:0] ix;
  logic [10:0] iy;
  logic [7:0]  oR;
  logic [7:0]  oG;
  logic [7:0]  oB;
  logic        mask;
  logic        wrap;
  logic        passed;

  modport master (
    output frame_tick, run, gap_y_in, ix, iy,
    input  oR, oG, oB, mask, wrap, passed
  );

  modport slave (
    input  frame_tick, run, gap_y_in, ix, iy,
    output oR, oG, oB, mask, wrap, passed
  );
endinterface

// File: rtl/tube_column_gen.sv
// Scrolling tube column: position/gap state plus a 2-cycle pixel colour pipeline; no backpressure.
// Define TUBE_LFSR_EN to draw respawn gaps from an internal LFSR instead of gap_y_in.
module tube_column_gen #(
  parameter int TUBE_W   = 16,
  parameter int GAP_H    = 64,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPEED    = 1,
  parameter int BIRD_X   = 160
) (
  input  logic               clk,
  input  logic               rst_n,
  tube_column_gen_if.slave   bus
);

  localparam int SHIFT = $clog2(TUBE_W) - 4;
  localparam logic signed [12:0] SPEED_S  = 13'(SPEED);
  localparam logic signed [12:0] TUBE_W_S = 13'(TUBE_W);
  localparam logic signed [12:0] NEG_TW_S = 13'(-TUBE_W);
  localparam logic signed [12:0] BIRD_S   = 13'(BIRD_X);
  localparam logic signed [11:0] SPAWN_X  = 12'(SCREEN_W);
  localparam logic [10:0] GAP_LO  = 11'd16;
  localparam logic [10:0] GAP_HI  = 11'(SCREEN_H - GAP_H - 16);
  localparam logic [10:0] GAP_RST = 11'((SCREEN_H - GAP_H) / 2);

  logic signed [11:0] tube_x_q, tube_x_d;
  logic [10:0]        gap_top_q, gap_top_d;
  logic               wrap_q, wrap_d;
  logic               passed_q, passed_d;
  logic [10:0]        gap_src;
  logic [10:0]        gap_clamped;

`ifdef TUBE_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.frame_tick) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  logic unused_gap_in;
  assign unused_gap_in = ^bus.gap_y_in;
  assign gap_src = lfsr_q[10:0];
`else
  assign gap_src = bus.gap_y_in;
`endif

  // Unsigned saturating clamp; the source is never allowed to wrap around.
  always_comb begin
    if (gap_src < GAP_LO)      gap_clamped = GAP_LO;
    else if (gap_src > GAP_HI) gap_clamped = GAP_HI;
    else                       gap_clamped = gap_src;
  end

  logic signed [12:0] x_ext, nx;
  assign x_ext = {tube_x_q[11], tube_x_q};
  assign nx    = x_ext - SPEED_S;

  always_comb begin
    tube_x_d  = tube_x_q;
    gap_top_d = gap_top_q;
    wrap_d    = 1'b0;
    passed_d  = 1'b0;
    if (bus.frame_tick && bus.run) begin
      if ((x_ext + TUBE_W_S >= BIRD_S) && (nx + TUBE_W_S < BIRD_S)) passed_d = 1'b1;
      if (nx <= NEG_TW_S) begin
        tube_x_d  = SPAWN_X;
        gap_top_d = gap_clamped;
        wrap_d    = 1'b1;
      end else begin
        tube_x_d  = nx[11:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tube_x_q  <= SPAWN_X;
      gap_top_q <= GAP_RST;
      wrap_q    <= 1'b0;
      passed_q  <= 1'b0;
    end else begin
      tube_x_q  <= tube_x_d;
      gap_top_q <= gap_top_d;
      wrap_q    <= wrap_d;
      passed_q  <= passed_d;
    end
  end

  // Stage 1 looks at the pre-update tube_x_q, so same-cycle scrolls do not affect this lookup.
  logic signed [12:0] ix_s, rel;
  logic [11:0]        iy_e, gt_e, gb_e;
  logic               in_x, above, below;
  logic               hit_d, cap_d;
  logic [3:0]         stripe_d;

  always_comb begin
    ix_s     = {2'b00, bus.ix};
    rel      = ix_s - x_ext;
    iy_e     = {1'b0, bus.iy};
    gt_e     = {1'b0, gap_top_q};
    gb_e     = gt_e + 12'(GAP_H);
    in_x     = (rel >= 13'sd0) && (rel < TUBE_W_S);
    above    = iy_e < gt_e;
    below    = iy_e >= gb_e;
    hit_d    = in_x && (above || below);
    cap_d    = (above && (iy_e + 12'd8 >= gt_e)) || (below && (iy_e < gb_e + 12'd8));
    stripe_d = hit_d ? rel[SHIFT +: 4] : 4'd0;
  end

  logic       hit_q, cap_q;
  logic [3:0] stripe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= 1'b0;
      cap_q    <= 1'b0;
      stripe_q <= 4'd0;
    end else begin
      hit_q    <= hit_d;
      cap_q    <= cap_d;
      stripe_q <= stripe_d;
    end
  end

  logic [11:0] pal;
  logic [3:0]  r_n, g_n, b_n;
  logic [7:0]  r_d, g_d, b_d;
  logic        mask_d;

  always_comb begin
    case (stripe_q)
      4'd2, 4'd8, 4'd9: pal = 12'h0A0;
      4'd13:            pal = 12'h000;
      4'd14, 4'd15:     pal = 12'h59F;
      default:          pal = 12'h8D1;
    endcase
    r_n = pal[11:8];
    g_n = pal[7:4];
    b_n = pal[3:0];
    if (cap_q) begin
      r_n = {1'b0, r_n[3:1]};
      g_n = {1'b0, g_n[3:1]};
      b_n = {1'b0, b_n[3:1]};
    end
    mask_d = hit_q;
    r_d    = hit_q ? {r_n, 4'b0000} : 8'h00;
    g_d    = hit_q ? {g_n, 4'b0000} : 8'h00;
    b_d    = hit_q ? {b_n, 4'b0000} : 8'h00;
  end

  logic [7:0] r_q, g_q, b_q;
  logic       mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= 8'h00;
      g_q    <= 8'h00;
      b_q    <= 8'h00;
      mask_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      mask_q <= mask_d;
    end
  end

  assign bus.oR     = r_q;
  assign bus.oG     = g_q;
  assign bus.oB     = b_q;
  assign bus.mask   = mask_q;
  assign bus.wrap   = wrap_q;
  assign bus.passed = passed_q;

endmodule
